// File: rtl/ctech_lib_cdc_hs_arb.sv
// rtl/ctech_lib_cdc_hs_arb.sv - round-robin arbiter feeding a 4-phase req/ack bundled-data CDC source
module ctech_lib_cdc_hs_arb #(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 3,
   localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_vld,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_rdy,
   output logic                     xfer_req,
   output logic [WIDTH-1:0]         xfer_data,
   input  logic                     xfer_ack,
   output logic [IW-1:0]            last_gnt,
   output logic                     busy,
   output logic                     done,
   output logic                     proto_err
);

   typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic [SYNC_STAGES-1:0] flush;
   logic                   ack_s, ack_s_d, sync_ok;
   logic [NUM_REQ-1:0]     gnt_vec;
   logic [IW-1:0]          gnt_idx;
   logic                   gnt_any;
   logic                   accept;

   assign ack_s   = ack_sync[SYNC_STAGES-1];
   // ack_s only counts as a real sample once the chain has refilled after reset
   assign sync_ok = flush[SYNC_STAGES-1];
   assign accept  = |(req_rdy & req_vld);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_sync <= '0;
         flush    <= '0;
         ack_s_d  <= 1'b0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], xfer_ack};
         flush    <= {flush[SYNC_STAGES-2:0], 1'b1};
         ack_s_d  <= ack_s;
      end
   end

   always_comb begin
      int           sum;
      logic [IW-1:0] cand;
      gnt_vec = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      sum     = 0;
      cand    = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         sum = int'(last_gnt) + off;
         if (sum >= NUM_REQ) sum = sum - NUM_REQ;
         cand = IW'(sum);
         if (!gnt_any && req_vld[cand]) begin
            gnt_any       = 1'b1;
            gnt_idx       = cand;
            gnt_vec[cand] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = REQ_HI;
         REQ_HI:  if (ack_s)  state_nxt = REQ_LO;
         REQ_LO:  if (!ack_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_rdy = '0;
      busy    = (state != IDLE);
      if (state == IDLE && sync_ok && !ack_s && gnt_any) req_rdy = gnt_vec;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xfer_req  <= 1'b0;
         xfer_data <= '0;
         last_gnt  <= IW'(NUM_REQ - 1);
         done      <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         done <= (state == REQ_LO) && !ack_s;
         if (accept) begin
            xfer_req  <= 1'b1;
            xfer_data <= req_data[gnt_idx*WIDTH +: WIDTH];
            last_gnt  <= gnt_idx;
         end else if (state == REQ_HI && ack_s) begin
            xfer_req <= 1'b0;
         end
         if ((state == IDLE && ack_s && !ack_s_d) || (state == REQ_HI && !ack_s && ack_s_d))
            proto_err <= 1'b1;
      end
   end

endmodule
